// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: EX-stage ALU with HI/LO and iterative mult/div, the latter present only when ALU_MULDIV_EN is defined
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] db,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [4:0] OP_ADD = 5'd0, OP_ADDU = 5'd1, OP_SUB = 5'd2, OP_SUBU = 5'd3,
                         OP_AND = 5'd4, OP_OR = 5'd5, OP_XOR = 5'd6, OP_NOR = 5'd7,
                         OP_SLT = 5'd8, OP_SLTU = 5'd9, OP_SLL = 5'd10, OP_SRL = 5'd11,
                         OP_SRA = 5'd12, OP_LUI = 5'd13, OP_MFHI = 5'd18, OP_MFLO = 5'd19,
                         OP_MTHI = 5'd20, OP_MTLO = 5'd21;
  logic               r_out_valid, r_ovf, r_ill;
  logic [WIDTH-1:0]   r_dout, r_hi, r_lo;
  logic [WIDTH-1:0]   w_res, w_sum, w_dif;
  logic [SHAMT_W-1:0] w_sh;
  logic               w_ovf, w_ill, w_acc, w_sc_acc, w_fin, w_md_op;
  assign w_sum = da + db;
  assign w_dif = da - db;
  assign w_sh = da[SHAMT_W-1:0];
  assign w_acc = in_valid & in_ready & ~flush;
  assign w_sc_acc = w_acc & ~w_md_op;
  assign out_valid = r_out_valid;
  assign dout = r_dout;
  assign out_ovf = r_ovf;
  assign out_illegal = r_ill;
  assign hi = r_hi;
  assign lo = r_lo;
`ifdef ALU_MULDIV_EN
  localparam logic [4:0] OP_MULT = 5'd14, OP_MULTU = 5'd15, OP_DIV = 5'd16, OP_DIVU = 5'd17;
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
  logic [1:0]         r_state;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_last, r_div, r_sgn;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   w_ma, w_mb, w_q, w_r, w_fhi, w_flo;
  logic [2*WIDTH-1:0] w_prod, w_mul_nx, w_div_nx;
  logic [WIDTH:0]     w_add, w_t, w_d;
  logic               w_sgn_in, w_na, w_nb;
  assign in_ready = r_state != S_BUSY;
  assign w_md_op = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign w_sgn_in = op == OP_MULT || op == OP_DIV;
  assign w_fin = r_state == S_BUSY && r_last && !flush;
  assign w_ma = (w_sgn_in && da[WIDTH-1]) ? -da : da;
  assign w_na = r_sgn & r_a[WIDTH-1];
  assign w_nb = r_sgn & r_b[WIDTH-1];
  assign w_mb = w_nb ? -r_b : r_b;
  assign w_add = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, w_mb} : '0);
  assign w_mul_nx = {w_add, r_p[WIDTH-1:1]};
  assign w_t = r_p[2*WIDTH-1:WIDTH-1];
  assign w_d = w_t - {1'b0, w_mb};
  assign w_div_nx = w_d[WIDTH] ? {w_t[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                               : {w_d[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
  assign w_prod = (w_na ^ w_nb) ? -r_p : r_p;
  assign w_q = (w_na ^ w_nb) ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_r = w_na ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  assign w_fhi = !r_div ? w_prod[2*WIDTH-1:WIDTH] : (r_b == '0) ? r_a : w_r;
  assign w_flo = !r_div ? w_prod[WIDTH-1:0] : (r_b == '0) ? '1 : w_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_last <= 1'b0;
      r_div <= 1'b0;
      r_sgn <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (r_state == S_BUSY) begin
      if (r_last) begin
        r_state <= S_DONE;
      end else begin
        r_p <= r_div ? w_div_nx : w_mul_nx;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        else r_last <= 1'b1;
      end
    end else if (w_acc && w_md_op) begin
      r_state <= S_BUSY;
      r_cnt <= SHAMT_W'(WIDTH - 1);
      r_last <= 1'b0;
      r_div <= op == OP_DIV || op == OP_DIVU;
      r_sgn <= w_sgn_in;
      r_a <= da;
      r_b <= db;
      r_p <= {{WIDTH{1'b0}}, w_ma};
    end else begin
      r_state <= S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fin) begin
      r_hi <= w_fhi;
      r_lo <= w_flo;
    end else if (w_sc_acc) begin
      if (op == OP_MTHI) r_hi <= da;
      if (op == OP_MTLO) r_lo <= da;
    end
  end
`else
  assign in_ready = 1'b1;
  assign w_md_op = 1'b0;
  assign w_fin = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_sc_acc) begin
      if (op == OP_MTHI) r_hi <= da;
      if (op == OP_MTLO) r_lo <= da;
    end
  end
`endif
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (da[WIDTH-1] == db[WIDTH-1]) && (w_sum[WIDTH-1] != da[WIDTH-1]);
      end
      OP_ADDU: w_res = w_sum;
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (da[WIDTH-1] != db[WIDTH-1]) && (w_dif[WIDTH-1] != da[WIDTH-1]);
      end
      OP_SUBU: w_res = w_dif;
      OP_AND: w_res = da & db;
      OP_OR: w_res = da | db;
      OP_XOR: w_res = da ^ db;
      OP_NOR: w_res = ~(da | db);
      OP_SLT: w_res = WIDTH'($signed(da) < $signed(db));
      OP_SLTU: w_res = WIDTH'(da < db);
      OP_SLL: w_res = db << w_sh;
      OP_SRL: w_res = db >> w_sh;
      OP_SRA: w_res = $signed(db) >>> w_sh;
      OP_LUI: w_res = {db[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
      OP_MTHI, OP_MTLO: w_res = '0;
`ifdef ALU_MULDIV_EN
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_res = '0;
`endif
      default: w_ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_dout <= '0;
      r_ovf <= 1'b0;
      r_ill <= 1'b0;
    end else begin
      r_out_valid <= w_sc_acc | w_fin;
      if (w_sc_acc | w_fin) begin
        r_dout <= w_sc_acc ? w_res : '0;
        r_ovf <= w_sc_acc & w_ovf;
        r_ill <= w_sc_acc & w_ill;
      end
    end
  end
endmodule
